// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the digit-serial ALU.
// The opcode values match the select field driven by the register file stage.
package alu_pkg;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-bit ALU slice: a ripple chain of 1-bit cells plus the logic ops.
// The carry into the top cell is exported so the top level can derive signed overflow.
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic [2:0]       select,
  input  logic             c_in,
  output logic [DIGIT-1:0] y,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [DIGIT:0]   carry;
  logic [DIGIT-1:0] b_eff;
  logic [DIGIT-1:0] sum;

  // Subtraction is a + ~b with the carry-in preloaded to 1 by the top level.
  always_comb begin
    carry[0] = c_in;
    b_eff    = (select == OP_SUB) ? ~b : b;
    sum      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
      carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    case (select)
      OP_NOT:         y = ~a;
      OP_NAND:        y = ~(a & b);
      OP_NOR:         y = ~(a | b);
      OP_ADD, OP_SUB: y = sum;
      default:        y = a;
    endcase
  end

  assign c_out    = carry[DIGIT];
  assign c_msb_in = carry[DIGIT-1];

endmodule

// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: consumes a WIDTH-bit operation DIGIT bits per clock, LSB digit first,
// with valid/ready handshakes on both sides and flags produced alongside the result.
module alu_digit_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig_y;
  logic             dig_c_out;
  logic             dig_c_msb_in;
  logic [WIDTH-1:0] result_next;
  logic             is_arith;

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .select   (op),
    .c_in     (carry),
    .y        (dig_y),
    .c_out    (dig_c_out),
    .c_msb_in (dig_c_msb_in)
  );

  // New digits enter at the top so that after NDIG shifts the LSB digit sits at bit 0.
  assign result_next = (result >> DIGIT) | (WIDTH'(dig_y) << (WIDTH - DIGIT));
  assign is_arith    = (op == OP_ADD) || (op == OP_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      op        <= OP_MOV;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            op       <= select;
            carry    <= (select == OP_SUB);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          result <= result_next;
          carry  <= dig_c_out;
          // Flags come from the final digit's carries; logic ops report no carry or overflow.
          if (cnt == LAST_DIGIT) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            c_out     <= is_arith & dig_c_out;
            overflow  <= is_arith & (dig_c_out ^ dig_c_msb_in);
            zero      <= (result_next == '0);
            negative  <= result_next[WIDTH-1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_digit_serial.sv
// Randomised and directed checks of alu_digit_serial against a plain-arithmetic model,
// with DIGIT=4 as the main instance and DIGIT=16 / DIGIT=1 instances sharing its inputs.
module tb_alu_digit_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  select = '0;

  logic        in_ready, out_valid, c_out, overflow, zero, negative;
  logic [15:0] result;
  logic        d16_in_ready, d16_out_valid, d16_c_out, d16_overflow, d16_zero, d16_negative;
  logic [15:0] d16_result;
  logic        d1_in_ready, d1_out_valid, d1_c_out, d1_overflow, d1_zero, d1_negative;
  logic [15:0] d1_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_digit_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .select(select), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c_out(c_out), .overflow(overflow), .zero(zero), .negative(negative)
  );

  alu_digit_serial #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d16_in_ready), .a(a), .b(b),
    .select(select), .out_valid(d16_out_valid), .out_ready(out_ready), .result(d16_result),
    .c_out(d16_c_out), .overflow(d16_overflow), .zero(d16_zero), .negative(d16_negative)
  );

  alu_digit_serial #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready), .a(a), .b(b),
    .select(select), .out_valid(d1_out_valid), .out_ready(out_ready), .result(d1_result),
    .c_out(d1_c_out), .overflow(d1_overflow), .zero(d1_zero), .negative(d1_negative)
  );

  // Reference: {result, c_out, overflow, zero, negative} from whole-word arithmetic.
  function automatic logic [19:0] ref_alu(input logic [2:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, ov;
    c  = 1'b0;
    ov = 1'b0;
    case (op)
      3'b001: r = ~x;
      3'b011: r = ~(x & y);
      3'b100: r = ~(x | y);
      3'b110: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[15:0];
        c  = s[16];
        ov = (x[15] == y[15]) && (r[15] != x[15]);
      end
      3'b101: begin
        r  = x - y;
        c  = (x >= y);
        ov = (x[15] != y[15]) && (r[15] != x[15]);
      end
      default: r = x;
    endcase
    return {r, c, ov, (r == 16'h0000), r[15]};
  endfunction

  // Issues one operation on the main instance and counts edges until out_valid (bounded).
  task automatic issue_and_wait(input logic [2:0] op, input logic [15:0] x,
                                input logic [15:0] y, output int lat);
    select   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({in_ready, out_valid, result, c_out, overflow, zero, negative} !== {2'b10, 20'h0}) begin
      failures++;
      $display("[TB] FAIL reset_state got=%b exp=%b",
               {in_ready, out_valid, result, c_out, overflow, zero, negative}, {2'b10, 20'h0});
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [6] = '{3'b110, 3'b101, 3'b101, 3'b011, 3'b100, 3'b111};
    logic [15:0] xs  [6] = '{16'h7FFF, 16'h0005, 16'h0000, 16'hFFFF, 16'h00F0, 16'h1234};
    logic [15:0] ys  [6] = '{16'h0001, 16'h0005, 16'h0001, 16'h0F0F, 16'h0F00, 16'hABCD};
    logic [19:0] exp [6] = '{{16'h8000, 4'b0101}, {16'h0000, 4'b1010}, {16'hFFFF, 4'b0001},
                             {16'hF0F0, 4'b0001}, {16'hF00F, 4'b0001}, {16'h1234, 4'b0000}};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue_and_wait(ops[i], xs[i], ys[i], lat);
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("[TB] FAIL directed_latency[%0d] got=%0d exp=4", i, lat);
      end
      checks++;
      if ({result, c_out, overflow, zero, negative} !== exp[i]) begin
        failures++;
        $display("[TB] FAIL directed_result[%0d] got=%h exp=%h", i,
                 {result, c_out, overflow, zero, negative}, exp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [15:0] x, y;
    logic [19:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = 16'($urandom);
      y  = (i % 8 == 0) ? x : 16'($urandom);
      exp = ref_alu(op, x, y);
      issue_and_wait(op, x, y, lat);
      checks++;
      if (lat !== 4 || {result, c_out, overflow, zero, negative} !== exp) begin
        failures++;
        $display("[TB] FAIL random[%0d] op=%b a=%h b=%h got=%h lat=%0d exp=%h lat=4", i, op, x, y,
                 {result, c_out, overflow, zero, negative}, lat, exp);
      end
      release_result();
    end
  endtask

  task automatic test_hold_in_done();
    logic [19:0] exp;
    int lat;
    exp = ref_alu(3'b101, 16'h1000, 16'h2345);
    issue_and_wait(3'b101, 16'h1000, 16'h2345, lat);
    in_valid = 1'b1;
    select   = 3'b110;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, result, c_out, overflow, zero, negative} !== {2'b10, exp}) begin
        failures++;
        $display("[TB] FAIL hold_stable[%0d] got=%h exp=%h", i,
                 {out_valid, in_ready, result, c_out, overflow, zero, negative}, {2'b10, exp});
      end
    end
    in_valid = 1'b0;
    release_result();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL hold_ignored_issue got=%b exp=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [19:0] exp;
    int lat;
    select   = 3'b110;
    a        = 16'h1111;
    b        = 16'h2222;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, result} !== {2'b10, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL rst_mid_run got=%h exp=%h", {in_ready, out_valid, result},
               {2'b10, 16'h0000});
    end
    exp = ref_alu(3'b110, 16'h8001, 16'h8001);
    issue_and_wait(3'b110, 16'h8001, 16'h8001, lat);
    checks++;
    if (lat !== 4 || {result, c_out, overflow, zero, negative} !== exp) begin
      failures++;
      $display("[TB] FAIL rst_then_op got=%h lat=%0d exp=%h lat=4",
               {result, c_out, overflow, zero, negative}, lat, exp);
    end
    release_result();
  endtask

  task automatic test_select_change();
    logic [19:0] exp;
    int lat;
    exp = ref_alu(3'b101, 16'h0100, 16'h0001);
    select   = 3'b101;
    a        = 16'h0100;
    b        = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    select   = 3'b011;
    a        = 16'hAAAA;
    b        = 16'h5555;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || {result, c_out, overflow, zero, negative} !== exp) begin
      failures++;
      $display("[TB] FAIL select_change got=%h lat=%0d exp=%h lat=4",
               {result, c_out, overflow, zero, negative}, lat, exp);
    end
    release_result();
  endtask

  task automatic test_digit_variants();
    logic [2:0]  ops [2] = '{3'b110, 3'b101};
    logic [15:0] xs  [2] = '{16'hFFFF, 16'h8000};
    logic [15:0] ys  [2] = '{16'h0001, 16'h0001};
    logic [19:0] exp;
    int lat4, lat16, lat1;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      exp = ref_alu(ops[k], xs[k], ys[k]);
      select   = ops[k];
      a        = xs[k];
      b        = ys[k];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat4 = 0; lat16 = 0; lat1 = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        @(posedge clk); #1;
        if (out_valid && lat4 == 0) lat4 = cyc;
        if (d16_out_valid && lat16 == 0) lat16 = cyc;
        if (d1_out_valid && lat1 == 0) lat1 = cyc;
        if (lat4 != 0 && lat16 != 0 && lat1 != 0) break;
      end
      checks++;
      if ({lat16, lat4, lat1} !== {32'd1, 32'd4, 32'd16}) begin
        failures++;
        $display("[TB] FAIL variant_latency[%0d] got d16=%0d d4=%0d d1=%0d exp 1/4/16", k,
                 lat16, lat4, lat1);
      end
      checks++;
      if ({d16_result, d16_c_out, d16_overflow, d16_zero, d16_negative} !== exp) begin
        failures++;
        $display("[TB] FAIL variant_d16[%0d] got=%h exp=%h", k,
                 {d16_result, d16_c_out, d16_overflow, d16_zero, d16_negative}, exp);
      end
      checks++;
      if ({d1_result, d1_c_out, d1_overflow, d1_zero, d1_negative} !== exp) begin
        failures++;
        $display("[TB] FAIL variant_d1[%0d] got=%h exp=%h", k,
                 {d1_result, d1_c_out, d1_overflow, d1_zero, d1_negative}, exp);
      end
      checks++;
      if ({result, c_out, overflow, zero, negative} !== exp) begin
        failures++;
        $display("[TB] FAIL variant_d4[%0d] got=%h exp=%h", k,
                 {result, c_out, overflow, zero, negative}, exp);
      end
      release_result();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_random();
    test_hold_in_done();
    test_reset_mid_run();
    test_select_change();
    test_digit_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
